pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Fetch and next-PC stage of the single-cycle MIPS core. It sits directly upstream and downstream of `program_counter`: it consumes `PC_out` to fetch the instruction word over a req/ack instruction-memory handshake. It then computes the next PC from the control unit's branch/jump decisions and drives `PC_in`. `program_counter` loads `PC_in` on every rising `clk`, so this block drives `PC_in = PC_out` whenever the PC must hold.

## Interface
Parameters
- RESET_VECTOR, 32'h0000_0000, address loaded into the PC during reset; must be word-aligned.

Ports
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- PC_out  in  32  current PC from `program_counter`.
- PC_in  out  32  next PC to `program_counter`.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; always equals PC_out.
- imem_ack  in  1  memory has `imem_rdata` valid this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction register.
- instr_valid  out  1  `instr` is current; the execute cycle.
- branch_taken  in  1  conditional branch resolved taken; sampled only while instr_valid.
- branch_offset  in  16  signed imm16 word offset.
- jump  in  1  J/JAL; sampled only while instr_valid.
- jump_target  in  26  instr_index field.
- jr  in  1  JR/JALR; sampled only while instr_valid.
- jr_addr  in  32  register-sourced target.
- halt_req  in  1  BREAK/SYSCALL stop request; sampled only while instr_valid.
- halted  out  1  block is in HALT.
- addr_err  out  1  sticky misaligned-JR flag.
- retired_count  out  32  count of instructions retired.

## Operation
FSM states:
- REQ
  - imem_req=1.
  - On imem_ack: `instr` <= imem_rdata; go to VALID.
  - Else stay in REQ; req is held continuously until ack.
- VALID
  - instr_valid=1 for exactly one cycle.
  - Next PC is selected combinationally in this cycle; next state is REQ.
  - Exceptions: halt_req or a misaligned jr goes to HALT instead.
- HALT
  - Terminal; imem_req=0, instr_valid=0, halted=1.
  - Left only by rst.

PC_in:
- rst=1: PC_in = RESET_VECTOR.
- REQ and HALT: PC_in = PC_out (hold).
- VALID: target selected by priority halt_req > jr > jump > branch_taken > sequential.
  - seq = PC_out + 4.
  - branch = seq + (sign_extend(branch_offset) << 2).
  - jump = {seq[31:28], jump_target, 2'b00}.
  - jr = jr_addr. If jr_addr[1:0] != 0: set addr_err, PC_in = PC_out, go to HALT.
  - halt_req: PC_in = PC_out, no retire.
- All additions are modulo 2^32; wrap from 32'hFFFF_FFFC + 4 gives 0 with no flag.

Counter and reset:
- retired_count increments by 1 on each VALID cycle that advances the PC (not halt_req, not misaligned jr). Wraps at 2^32.
- Reset values: state REQ, instr=0, addr_err=0, retired_count=0.
- imem_req is asserted in the first cycle after rst falls.
- rst mid-REQ: a pending ack is ignored; the memory model must tolerate a dropped request.

## Timing
- Minimum 2 cycles per instruction (REQ with same-cycle ack, then VALID). With N wait cycles: N+2.
- PC_out changes only on the edge ending VALID, or during reset. imem_addr is stable for the whole request.
- instr is registered; it updates on the edge leaving REQ with ack and is stable through VALID.
- Control inputs are combinational into PC_in during VALID; they are ignored in every other state.
- imem_ack in VALID or HALT is ignored.
- Simultaneous jr and jump: jr wins. halt_req with any target: halt wins.

## Test plan
- Reset: rst high 2 cycles with PC_out=X. Required: PC_in=RESET_VECTOR. After release: PC_out=0, imem_req=1, imem_addr=0, retired_count=0.
- Sequential fetch, ack latency 0 then 3. Required:
  - Fetches at 0x0 and 0x4.
  - instr_valid pulses exactly once per instruction, with 2- and 5-cycle spacing.
  - retired_count=2.
  - imem_addr stable throughout the wait.
- Branches from PC_out=0x10:
  - branch_offset=16'hFFFF, taken: PC_in=0x10.
  - offset=16'h0004: PC_in=0x24.
  - Not taken: 0x14.
- Jump and JR:
  - PC_out=0xA000_0000, jump_target=26'h000_0040: PC_in=0xA000_0100.
  - jr with jr_addr=0x0000_2000 while jump=1: PC_in=0x2000.
- Misaligned jr_addr=0x0000_2002: PC_in=PC_out, addr_err=1, halted=1, imem_req=0 thereafter. retired_count is unchanged. rst clears all.
- Reset mid-WAIT: rst during REQ before ack with memory acking in the same cycle. Required: instr=0, state REQ, and fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_sequencer_if : instruction-memory req/ack handshake bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_sequencer : fetch + next-PC stage wrapped around program_counter
// Revision: 1.0
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_out,
  output logic [31:0] PC_in,
  pc_fetch_sequencer_if.master imem,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        halt_req,
  output logic        halted,
  output logic        addr_err,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_VALID = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        addr_err_q, addr_err_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic [31:0] seq_pc;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] target_pc;
  logic        bad_jr;
  logic        retire;

  // Target selection; halt_req outranks a misaligned jr, so it never flags addr_err.
  always_comb begin
    seq_pc    = PC_out + 32'd4;
    branch_pc = seq_pc + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    jump_pc   = {seq_pc[31:28], jump_target, 2'b00};
    bad_jr    = !halt_req && jr && (jr_addr[1:0] != 2'b00);
    if (halt_req)          target_pc = PC_out;
    else if (jr)           target_pc = bad_jr ? PC_out : jr_addr;
    else if (jump)         target_pc = jump_pc;
    else if (branch_taken) target_pc = branch_pc;
    else                   target_pc = seq_pc;
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    retired_d  = retired_q;
    addr_err_d = addr_err_q;
    retire     = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (halt_req || bad_jr) begin
          state_d    = ST_HALT;
          addr_err_d = addr_err_q | bad_jr;
        end else begin
          retire  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_REQ;
    endcase
    if (retire) retired_d = retired_q + 32'd1;
    req_d    = (state_d == ST_REQ);
    valid_d  = (state_d == ST_VALID);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      instr_q    <= 32'd0;
      retired_q  <= 32'd0;
      addr_err_q <= 1'b0;
      req_q      <= 1'b1;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      retired_q  <= retired_d;
      addr_err_q <= addr_err_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  // program_counter loads PC_in every edge, so every non-VALID state feeds PC_out back.
  always_comb begin
    if (rst)                    PC_in = RESET_VECTOR;
    else if (state_q == ST_VALID) PC_in = target_pc;
    else                        PC_in = PC_out;
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = PC_out;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign halted         = halted_q;
  assign addr_err       = addr_err_q;
  assign retired_count  = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer : directed bench with a behavioural program_counter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_out;
  logic [31:0] pc_in;
  logic        pc_set_en  = 1'b0;
  logic [31:0] pc_set_val = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        branch_taken  = 1'b0;
  logic [15:0] branch_offset = 16'd0;
  logic        jump          = 1'b0;
  logic [25:0] jump_target   = 26'd0;
  logic        jr            = 1'b0;
  logic [31:0] jr_addr       = 32'd0;
  logic        halt_req      = 1'b0;
  logic        halted;
  logic        addr_err;
  logic [31:0] retired_count;

  int tests_run    = 0;
  int tests_failed = 0;

  pc_fetch_sequencer_if imem_bus ();

  pc_fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .PC_out       (pc_out),
    .PC_in        (pc_in),
    .imem         (imem_bus),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .halt_req     (halt_req),
    .halted       (halted),
    .addr_err     (addr_err),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Stand-in for program_counter, with a back door to place the PC for directed tests.
  always @(posedge clk) pc_out <= pc_set_en ? pc_set_val : pc_in;

  task automatic clear_ctrl();
    branch_taken = 1'b0; branch_offset = 16'd0; jump = 1'b0; jump_target = 26'd0;
    jr = 1'b0; jr_addr = 32'd0; halt_req = 1'b0;
  endtask

  // Entered at a negedge with the DUT in REQ; returns at the negedge of the VALID cycle.
  task automatic ack_after(input int n, input logic [31:0] word);
    repeat (n) @(negedge clk);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_set_en = 1'b1; pc_set_val = v;
    @(negedge clk);
    pc_set_en = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (pc_in !== 32'h0) begin tests_failed++; $display("FAIL reset_pc_in: got %h expected %h", pc_in, 32'h0); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_pc_out: got %h expected %h", pc_out, 32'h0); end
    tests_run++;
    if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0)
      begin tests_failed++; $display("FAIL reset_req: got req=%b addr=%h expected req=1 addr=0", imem_bus.imem_req, imem_bus.imem_addr); end
    tests_run++;
    if (retired_count !== 32'd0 || instr !== 32'd0 || instr_valid !== 1'b0 || halted !== 1'b0 || addr_err !== 1'b0)
      begin tests_failed++; $display("FAIL reset_state: got rc=%0d instr=%h v=%b h=%b ae=%b expected all zero", retired_count, instr, instr_valid, halted, addr_err); end
  endtask

  task automatic test_sequential();
    int gap = -1;
    int pulses = 0;
    int addr_bad = 0;
    ack_after(0, 32'h1111_0001);
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'h1111_0001 || pc_in !== 32'h4)
      begin tests_failed++; $display("FAIL seq_first: got v=%b instr=%h pc_in=%h expected v=1 instr=11110001 pc_in=4", instr_valid, instr, pc_in); end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 4) begin imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h2222_0002; end
      else imem_bus.imem_ack = 1'b0;
      if (instr_valid === 1'b1) begin pulses++; if (gap < 0) gap = i; end
      if (i <= 4 && (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h4)) addr_bad++;
      if (i == 5) begin
        tests_run++;
        if (instr !== 32'h2222_0002 || pc_in !== 32'h8)
          begin tests_failed++; $display("FAIL seq_second: got instr=%h pc_in=%h expected 22220002 8", instr, pc_in); end
      end
    end
    tests_run++;
    if (gap !== 5 || pulses !== 1) begin tests_failed++; $display("FAIL seq_spacing: got gap=%0d pulses=%0d expected gap=5 pulses=1", gap, pulses); end
    tests_run++;
    if (addr_bad !== 0) begin tests_failed++; $display("FAIL seq_addr_stable: got %0d bad cycles expected 0", addr_bad); end
    tests_run++;
    if (retired_count !== 32'd2) begin tests_failed++; $display("FAIL seq_retired: got %0d expected 2", retired_count); end
  endtask

  task automatic test_branch();
    set_pc(32'h10);
    ack_after(0, 32'h1000_FFFF);
    branch_taken = 1'b1; branch_offset = 16'hFFFF; #1;
    tests_run++;
    if (pc_in !== 32'h10) begin tests_failed++; $display("FAIL branch_back: got %h expected %h", pc_in, 32'h10); end
    @(negedge clk); clear_ctrl();
    ack_after(0, 32'h1000_0004);
    branch_taken = 1'b1; branch_offset = 16'h0004; #1;
    tests_run++;
    if (pc_in !== 32'h24) begin tests_failed++; $display("FAIL branch_fwd: got %h expected %h", pc_in, 32'h24); end
    @(negedge clk); clear_ctrl();
    set_pc(32'h10);
    ack_after(0, 32'h1000_0008);
    branch_offset = 16'h0008; #1;
    tests_run++;
    if (pc_in !== 32'h14) begin tests_failed++; $display("FAIL branch_not_taken: got %h expected %h", pc_in, 32'h14); end
    @(negedge clk); clear_ctrl();
  endtask

  task automatic test_jump_jr();
    set_pc(32'hA000_0000);
    ack_after(0, 32'h0800_0040);
    jump = 1'b1; jump_target = 26'h000_0040; #1;
    tests_run++;
    if (pc_in !== 32'hA000_0100) begin tests_failed++; $display("FAIL jump: got %h expected %h", pc_in, 32'hA000_0100); end
    @(negedge clk); clear_ctrl();
    ack_after(1, 32'h0000_0008);
    jr = 1'b1; jr_addr = 32'h0000_2000; jump = 1'b1; jump_target = 26'h3FF_FFFF; #1;
    tests_run++;
    if (pc_in !== 32'h2000) begin tests_failed++; $display("FAIL jr_over_jump: got %h expected %h", pc_in, 32'h2000); end
    @(negedge clk); clear_ctrl();
    tests_run++;
    if (retired_count !== 32'd7 || pc_out !== 32'h2000)
      begin tests_failed++; $display("FAIL jr_retired: got rc=%0d pc=%h expected rc=7 pc=2000", retired_count, pc_out); end
  endtask

  task automatic test_misaligned_jr();
    int bad = 0;
    ack_after(0, 32'h0000_0009);
    jr = 1'b1; jr_addr = 32'h0000_2002; #1;
    tests_run++;
    if (pc_in !== 32'h2000) begin tests_failed++; $display("FAIL misjr_pc_in: got %h expected %h", pc_in, 32'h2000); end
    @(negedge clk); clear_ctrl();
    tests_run++;
    if (addr_err !== 1'b1 || halted !== 1'b1 || imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || retired_count !== 32'd7)
      begin tests_failed++; $display("FAIL misjr_halt: got ae=%b h=%b req=%b v=%b rc=%0d expected 1 1 0 0 7", addr_err, halted, imem_bus.imem_req, instr_valid, retired_count); end
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b0 || pc_out !== 32'h2000) bad++;
    end
    imem_bus.imem_ack = 1'b0;
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL misjr_terminal: got %0d bad cycles expected 0", bad); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (addr_err !== 1'b0 || halted !== 1'b0 || retired_count !== 32'd0 || imem_bus.imem_req !== 1'b1 || pc_out !== 32'h0)
      begin tests_failed++; $display("FAIL misjr_rst: got ae=%b h=%b rc=%0d req=%b pc=%h expected 0 0 0 1 0", addr_err, halted, retired_count, imem_bus.imem_req, pc_out); end
  endtask

  task automatic test_halt_req();
    ack_after(0, 32'h0000_000D);
    halt_req = 1'b1; jump = 1'b1; jump_target = 26'h000_0100; jr = 1'b1; jr_addr = 32'h0000_2002; #1;
    tests_run++;
    if (pc_in !== 32'h0) begin tests_failed++; $display("FAIL halt_pc_in: got %h expected %h", pc_in, 32'h0); end
    @(negedge clk); clear_ctrl();
    tests_run++;
    if (halted !== 1'b1 || addr_err !== 1'b0 || retired_count !== 32'd0 || imem_bus.imem_req !== 1'b0)
      begin tests_failed++; $display("FAIL halt_state: got h=%b ae=%b rc=%0d req=%b expected 1 0 0 0", halted, addr_err, retired_count, imem_bus.imem_req); end
  endtask

  task automatic test_reset_mid_wait();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ack_after(0, 32'h1234_5678);
    @(negedge clk);
    tests_run++;
    if (instr !== 32'h1234_5678 || pc_out !== 32'h4)
      begin tests_failed++; $display("FAIL midwait_pre: got instr=%h pc=%h expected 12345678 4", instr, pc_out); end
    rst = 1'b1; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0; imem_bus.imem_ack = 1'b0;
    tests_run++;
    if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0)
      begin tests_failed++; $display("FAIL midwait_rst: got instr=%h v=%b req=%b addr=%h expected 0 0 1 0", instr, instr_valid, imem_bus.imem_req, imem_bus.imem_addr); end
    @(negedge clk);
    tests_run++;
    if (instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1)
      begin tests_failed++; $display("FAIL midwait_drop: got v=%b req=%b expected 0 1", instr_valid, imem_bus.imem_req); end
    ack_after(0, 32'h0000_CAFE);
    #1;
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_CAFE || pc_in !== 32'h4)
      begin tests_failed++; $display("FAIL midwait_restart: got v=%b instr=%h pc_in=%h expected 1 0000cafe 4", instr_valid, instr, pc_in); end
    @(negedge clk);
  endtask

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump_jr();
    test_misaligned_jr();
    test_halt_req();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
